// File: rtl/mem_ref_control_unit.sv
// Moore control FSM sequencing fetch and execute of ld/ldi/st/halt on a bus datapath.
// Strobes decode from the current state and ir_op; memory steps wait on mem_done.
module mem_ref_control_unit #(
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [4:0] ir_op,
  input  logic       mem_done,
  output logic       PCout,
  output logic       IncPC,
  output logic       MARin,
  output logic       PCin,
  output logic       IRin,
  output logic       Read,
  output logic       Write,
  output logic       MDRin,
  output logic       MDRout,
  output logic       Gra,
  output logic       Grb,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       ADD,
  output logic       run,
  output logic [3:0] present_state
);

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd8
  } state_t;

  state_t state;
  state_t next_state;
  logic   pc_done;
  logic   is_ld;
  logic   is_ldi;
  logic   is_st;

  assign is_ld  = (ir_op == OP_LD);
  assign is_ldi = (ir_op == OP_LDI);
  assign is_st  = (ir_op == OP_ST);

  always_comb begin
    next_state = T0;
    case (state)
      T0: next_state = T1;
      T1: next_state = mem_done ? T2 : T1;
      T2: next_state = T3;
      T3: begin
        if (is_ld || is_ldi || is_st)
          next_state = T4;
        else if (ir_op == OP_HALT)
          next_state = HALT;
        else
          next_state = T0;
      end
      T4: next_state = (is_ld || is_ldi || is_st) ? T5 : T0;
      T5: next_state = (is_ld || is_st) ? T6 : T0;
      T6: begin
        if (is_ld)
          next_state = mem_done ? T7 : T6;
        else if (is_st)
          next_state = T7;
        else
          next_state = T0;
      end
      T7: next_state = (is_st && !mem_done) ? T7 : T0;
      HALT: next_state = HALT;
      default: next_state = T0;
    endcase
  end

  // pc_done drops outside T1, so only the first cycle of each T1 visit loads the PC.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= T0;
      pc_done <= 1'b0;
    end else begin
      state   <= next_state;
      pc_done <= (state == T1);
    end
  end

  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    IRin    = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    ADD     = 1'b0;
    if (!clear) begin
      case (state)
        T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zin   = 1'b1;
        end
        T1: begin
          Zlowout = 1'b1;
          PCin    = !pc_done;
          Read    = 1'b1;
          MDRin   = 1'b1;
        end
        T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        T3: begin
          if (is_ld || is_ldi || is_st) begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
        end
        T4: begin
          if (is_ld || is_ldi || is_st) begin
            Cout = 1'b1;
            ADD  = 1'b1;
            Zin  = 1'b1;
          end
        end
        T5: begin
          if (is_ld || is_st) begin
            Zlowout = 1'b1;
            MARin   = 1'b1;
          end else if (is_ldi) begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
        end
        T6: begin
          if (is_ld) begin
            Read  = 1'b1;
            MDRin = 1'b1;
          end else if (is_st) begin
            // Read stays low so the MDR captures Ra from the bus, not memory.
            Gra   = 1'b1;
            Rout  = 1'b1;
            MDRin = 1'b1;
          end
        end
        T7: begin
          if (is_ld) begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end else if (is_st) begin
            Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign run           = clear || (state != HALT);
  assign present_state = state;

endmodule

// File: tb/tb_mem_ref_control_unit.sv
// Self-checking bench: per-cycle vector table fed through an expected-value queue,
// plus bounded latency checks for each instruction class.
module tb_mem_ref_control_unit;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_BAD  = 5'b10101;

  localparam logic [18:0] S_PCOUT   = 19'd1 << 0;
  localparam logic [18:0] S_INCPC   = 19'd1 << 1;
  localparam logic [18:0] S_MARIN   = 19'd1 << 2;
  localparam logic [18:0] S_PCIN    = 19'd1 << 3;
  localparam logic [18:0] S_IRIN    = 19'd1 << 4;
  localparam logic [18:0] S_READ    = 19'd1 << 5;
  localparam logic [18:0] S_WRITE   = 19'd1 << 6;
  localparam logic [18:0] S_MDRIN   = 19'd1 << 7;
  localparam logic [18:0] S_MDROUT  = 19'd1 << 8;
  localparam logic [18:0] S_GRA     = 19'd1 << 9;
  localparam logic [18:0] S_GRB     = 19'd1 << 10;
  localparam logic [18:0] S_RIN     = 19'd1 << 11;
  localparam logic [18:0] S_ROUT    = 19'd1 << 12;
  localparam logic [18:0] S_BAOUT   = 19'd1 << 13;
  localparam logic [18:0] S_COUT    = 19'd1 << 14;
  localparam logic [18:0] S_YIN     = 19'd1 << 15;
  localparam logic [18:0] S_ZIN     = 19'd1 << 16;
  localparam logic [18:0] S_ZLOWOUT = 19'd1 << 17;
  localparam logic [18:0] S_ADD     = 19'd1 << 18;

  localparam logic [18:0] X_T0   = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
  localparam logic [18:0] X_T1A  = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [18:0] X_T1W  = S_ZLOWOUT | S_READ | S_MDRIN;
  localparam logic [18:0] X_T2   = S_MDROUT | S_IRIN;
  localparam logic [18:0] X_T3   = S_GRB | S_BAOUT | S_YIN;
  localparam logic [18:0] X_T4   = S_COUT | S_ADD | S_ZIN;
  localparam logic [18:0] X_T5M  = S_ZLOWOUT | S_MARIN;
  localparam logic [18:0] X_T5I  = S_ZLOWOUT | S_GRA | S_RIN;
  localparam logic [18:0] X_T6LD = S_READ | S_MDRIN;
  localparam logic [18:0] X_T6ST = S_GRA | S_ROUT | S_MDRIN;
  localparam logic [18:0] X_T7LD = S_MDROUT | S_GRA | S_RIN;
  localparam logic [18:0] X_T7ST = S_WRITE;

  typedef struct {
    logic        clr;
    logic [4:0]  op;
    logic        md;
    logic [3:0]  exp_state;
    logic [18:0] exp_strobes;
    logic        exp_run;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [18:0] strobes;
    logic        run;
  } exp_t;

  logic       clock;
  logic       clear;
  logic [4:0] ir_op;
  logic       mem_done;
  logic PCout, IncPC, MARin, PCin, IRin, Read, Write, MDRin, MDRout;
  logic Gra, Grb, Rin, Rout, BAout, Cout, Yin, Zin, Zlowout, ADD, run;
  logic [3:0] present_state;

  int total;
  int bad;
  vec_t vecs[$];
  exp_t expq[$];

  mem_ref_control_unit dut (
    .clock(clock), .clear(clear), .ir_op(ir_op), .mem_done(mem_done),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .PCin(PCin), .IRin(IRin),
    .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
    .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .ADD(ADD),
    .run(run), .present_state(present_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [18:0] strobes_now();
    return {ADD, Zlowout, Zin, Yin, Cout, BAout, Rout, Rin, Grb, Gra,
            MDRout, MDRin, Write, Read, IRin, PCin, MARin, IncPC, PCout};
  endfunction

  task automatic add(input logic clr, input logic [4:0] op, input logic md,
                     input logic [3:0] st, input logic [18:0] sb, input logic rn);
    vec_t v;
    v.clr = clr; v.op = op; v.md = md;
    v.exp_state = st; v.exp_strobes = sb; v.exp_run = rn;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    @(posedge clock);
    #1;
    clear    = v.clr;
    ir_op    = v.op;
    mem_done = v.md;
    e.st = v.exp_state; e.strobes = v.exp_strobes; e.run = v.exp_run;
    expq.push_back(e);
  endtask

  task automatic check_output(input int idx);
    exp_t e;
    @(negedge clock);
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL queue_empty vec=%0d", idx);
      return;
    end
    e = expq.pop_front();
    total++;
    if (present_state !== e.st || strobes_now() !== e.strobes || run !== e.run) begin
      bad++;
      $display("[TB] FAIL vec%0d state=%0d strobes=%05h run=%b, required state=%0d strobes=%05h run=%b",
               idx, present_state, strobes_now(), run, e.st, e.strobes, e.run);
    end
  endtask

  // Counts rising edges from a T0 cycle until the FSM is back in T0.
  task automatic check_latency(input logic [4:0] op, input int required, input string name);
    int cycles;
    cycles = 0;
    ir_op = op;
    mem_done = 1'b1;
    clear = 1'b0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (present_state != 4'd0 && cycles < 60);
    total++;
    if (cycles != required) begin
      bad++;
      $display("[TB] FAIL latency_%s cycles=%0d required=%0d", name, cycles, required);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clear = 1'b1;
    ir_op = OP_LD;
    mem_done = 1'b1;

    // reset held two cycles, then ld with no waits
    add(1, OP_LD, 1, 0, 19'd0, 1);
    add(0, OP_LD, 1, 0, X_T0, 1);
    add(0, OP_LD, 1, 1, X_T1A, 1);
    add(0, OP_LD, 1, 2, X_T2, 1);
    add(0, OP_LD, 1, 3, X_T3, 1);
    add(0, OP_LD, 1, 4, X_T4, 1);
    add(0, OP_LD, 1, 5, X_T5M, 1);
    add(0, OP_LD, 1, 6, X_T6LD, 1);
    add(0, OP_LD, 1, 7, X_T7LD, 1);
    // ld with 3 waits in T1 and 2 in T6
    add(0, OP_LD, 1, 0, X_T0, 1);
    add(0, OP_LD, 0, 1, X_T1A, 1);
    add(0, OP_LD, 0, 1, X_T1W, 1);
    add(0, OP_LD, 0, 1, X_T1W, 1);
    add(0, OP_LD, 1, 1, X_T1W, 1);
    add(0, OP_LD, 1, 2, X_T2, 1);
    add(0, OP_LD, 1, 3, X_T3, 1);
    add(0, OP_LD, 1, 4, X_T4, 1);
    add(0, OP_LD, 1, 5, X_T5M, 1);
    add(0, OP_LD, 0, 6, X_T6LD, 1);
    add(0, OP_LD, 0, 6, X_T6LD, 1);
    add(0, OP_LD, 1, 6, X_T6LD, 1);
    add(0, OP_LD, 1, 7, X_T7LD, 1);
    // st: mem_done low where it must be ignored, one write wait in T7
    add(0, OP_ST, 0, 0, X_T0, 1);
    add(0, OP_ST, 1, 1, X_T1A, 1);
    add(0, OP_ST, 0, 2, X_T2, 1);
    add(0, OP_ST, 0, 3, X_T3, 1);
    add(0, OP_ST, 0, 4, X_T4, 1);
    add(0, OP_ST, 0, 5, X_T5M, 1);
    add(0, OP_ST, 0, 6, X_T6ST, 1);
    add(0, OP_ST, 0, 7, X_T7ST, 1);
    add(0, OP_ST, 1, 7, X_T7ST, 1);
    // ldi
    add(0, OP_LDI, 1, 0, X_T0, 1);
    add(0, OP_LDI, 1, 1, X_T1A, 1);
    add(0, OP_LDI, 1, 2, X_T2, 1);
    add(0, OP_LDI, 1, 3, X_T3, 1);
    add(0, OP_LDI, 1, 4, X_T4, 1);
    add(0, OP_LDI, 1, 5, X_T5I, 1);
    // unknown opcode is a NOP
    add(0, OP_BAD, 1, 0, X_T0, 1);
    add(0, OP_BAD, 1, 1, X_T1A, 1);
    add(0, OP_BAD, 1, 2, X_T2, 1);
    add(0, OP_BAD, 1, 3, 19'd0, 1);
    // clear during T6 of ld while waiting
    add(0, OP_LD, 1, 0, X_T0, 1);
    add(0, OP_LD, 1, 1, X_T1A, 1);
    add(0, OP_LD, 1, 2, X_T2, 1);
    add(0, OP_LD, 1, 3, X_T3, 1);
    add(0, OP_LD, 1, 4, X_T4, 1);
    add(0, OP_LD, 1, 5, X_T5M, 1);
    add(0, OP_LD, 0, 6, X_T6LD, 1);
    add(1, OP_LD, 0, 6, 19'd0, 1);
    // clear inside a T1 wait must also restart PC loading
    add(0, OP_LD, 0, 0, X_T0, 1);
    add(0, OP_LD, 0, 1, X_T1A, 1);
    add(1, OP_LD, 0, 1, 19'd0, 1);
    add(0, OP_LD, 0, 0, X_T0, 1);
    add(0, OP_LD, 0, 1, X_T1A, 1);
    add(1, OP_LD, 0, 1, 19'd0, 1);
    // halt, parked for 20 cycles, then released by clear
    add(0, OP_HALT, 1, 0, X_T0, 1);
    add(0, OP_HALT, 1, 1, X_T1A, 1);
    add(0, OP_HALT, 1, 2, X_T2, 1);
    add(0, OP_HALT, 1, 3, 19'd0, 1);
    for (int i = 0; i < 20; i++)
      add(0, OP_HALT, logic'(i % 2), 8, 19'd0, 0);
    add(1, OP_HALT, 1, 8, 19'd0, 1);
    add(0, OP_LD, 1, 0, X_T0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(i);
    end

    // in T0 now (mid-cycle); measure full instruction latencies
    check_latency(OP_LD, 8, "ld");
    check_latency(OP_ST, 8, "st");
    check_latency(OP_LDI, 6, "ldi");
    check_latency(OP_BAD, 4, "nop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ref_control_unit.md
Name: mem_ref_control_unit

Overview:
- Moore-style control FSM that sequences the bus-based datapath through fetch and execute of memory-reference instructions: ld, ldi, st, halt.
- Drives the register-transfer strobes (PCout, MARin, IncPC, Zlowout, MDRout, Gra/Grb, BAout, Cout, Rin/Rout, ADD, Yin, Zin, Read/Write, MDRin, IRin) that the datapath consumes.
- Replaces hand-sequenced stimulus with a real per-state decode.
- Inserts memory wait states driven by a mem_done handshake.

Parameters:
- OP_LD, 5'b00000, IR[31:27] opcode for ld Ra,C(Rb)
- OP_LDI, 5'b00001, opcode for ldi Ra,C(Rb)
- OP_ST, 5'b00010, opcode for st C(Rb),Ra
- OP_HALT, 5'b11011, opcode for halt

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- ir_op  in  5  IR[31:27], valid from T3 onward
- mem_done  in  1  memory access complete, sampled in memory wait states
- PCout, IncPC, MARin, PCin, IRin  out  1  each; PC/MAR/IR strobes
- Read, Write, MDRin, MDRout  out  1  each; memory strobes
- Gra, Grb, Rin, Rout, BAout, Cout  out  1  each; register-select and bus strobes
- Yin, Zin, Zlowout, ADD  out  1  each; ALU strobes
- run  out  1  high while not halted
- present_state  out  4  state code, for debug and bench

Behaviour:
- Reset: clock and reset are fixed as one clock; clear is synchronous and active-high.
  - clear=1 at a rising edge forces state=T0 next cycle.
  - Asserted mid-instruction, clear aborts it, including inside a wait state.
  - While clear=1, run=1 and all strobes are 0 (strobes are gated by !clear).
- States (encoding): T0=0, T1=1, T2=2, T3=3, T4=4, T5=5, T6=6, T7=7, HALT=8. Codes 9-15 are illegal and go to T0.
- Strobes are a combinational function of the current state and ir_op only. Every unlisted strobe is 0.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin. PC is loaded in the first T1 cycle only, tracked by a pc_done flag cleared on T1 entry. Read and MDRin hold while waiting. Stay in T1 until mem_done=1, then go to T2.
- T2: MDRout, IRin. Go to T3.
- T3, by ir_op:
  - ld, ldi, st: Grb, BAout, Yin. Go to T4.
  - halt: no strobes. Go to HALT.
  - Any other opcode: NOP, go to T0.
- T4 (ld, ldi, st): Cout, ADD, Zin. Go to T5.
- T5:
  - ld, st: Zlowout, MARin. Go to T6.
  - ldi: Zlowout, Gra, Rin. Go to T0.
- T6:
  - ld: Read, MDRin. Hold until mem_done=1, then go to T7.
  - st: Gra, Rout, MDRin; Read=0 so the MDR takes the bus. Go to T7.
- T7:
  - ld: MDRout, Gra, Rin. Go to T0.
  - st: Write. Hold until mem_done=1, then go to T0.
- HALT: run=0, all strobes 0. Stays in HALT until clear.
- mem_done outside T1, T6(ld) or T7(st) is ignored.
- Latency with mem_done tied to 1:
  - ld: 8 cycles.
  - st: 8 cycles.
  - ldi: 6 cycles.
  - Unknown opcode: 4 cycles.
  - Each wait cycle adds 1.
- ir_op is sampled combinationally in T3-T7. The IR must hold it until the FSM returns to T0.

Test Plan:
- clear=1 for 2 cycles then 0, mem_done=1, ir_op=OP_LD: present_state runs 0,1,2,3,4,5,6,7,0. Strobes must match per state: T3 Grb/BAout/Yin, T4 Cout/ADD/Zin, T7 MDRout/Gra/Rin.
- ir_op=OP_LD, mem_done low for 3 cycles in T1 and 2 cycles in T6: T1 lasts 4 cycles, with PCin high in the first cycle only and Read/MDRin high throughout. T6 lasts 3 cycles. Total 13 cycles.
- ir_op=OP_ST, mem_done=1: T6 asserts Gra/Rout/MDRin with Read=0. T7 asserts Write only. Back to T0 after 8 cycles.
- ir_op=OP_LDI: state sequence 0-5 then 0. T5 has Zlowout/Gra/Rin. MARin stays 0 in T5.
- ir_op=OP_HALT: T3 goes to HALT (present_state=8), run=0, all strobes 0 for 20 cycles. clear=1 for one cycle returns state to 0 with run=1.
- clear asserted during T6 of ld with mem_done=0: next state is T0 and Read/MDRin are 0 during the clear cycle. ir_op=5'b10101 gives sequence 0,1,2,3,0 with no strobes in T3.
